// File: rtl/ifid_queue.sv
`default_nettype none
// ifid_queue: circular-buffer instruction queue between fetch and decode, with flush.
// Define IFQ_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module ifid_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 30,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_EMPTY = '0;

  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic w_has_data;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  assign w_has_data = (count_q != C_EMPTY);
  assign in_ready   = (count_q != C_FULL);
  assign count      = count_q;

`ifdef IFQ_BYPASS_EN
  // Empty queue with a willing consumer: hand the fetch word over without storing it.
  assign w_bypass = !w_has_data && !flush && in_valid && out_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = in_valid && in_ready && !w_bypass;
  assign w_pop  = w_has_data && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_comb begin
    out_valid = w_has_data;
    out_pc    = '0;
    out_instr = '0;
    if (w_bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (w_has_data) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifid_queue.sv
`default_nettype none
// tb_ifid_queue: directed and randomized checks of ifid_queue against a queue-based model.
module tb_ifid_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifid_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ent_t;

  ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit byp_now();
`ifdef IFQ_BYPASS_EN
    return (mq.size() == 0) && !flush && in_valid && out_ready;
`else
    return 1'b0;
`endif
  endfunction

  // Model state update: FIFO semantics from the handshake rules.
  bit   m_push, m_pop;
  ent_t m_e;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst || flush) begin
      mq.delete();
    end else begin
      m_push = in_valid && (mq.size() < DEPTH) && !byp_now();
      m_pop  = (mq.size() != 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_e.pc    = in_pc;
        m_e.instr = in_instr;
        mq.push_back(m_e);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic               e_valid;
  logic [PC_W-1:0]    e_pc;
  logic [INSTR_W-1:0] e_instr;
  initial forever begin
    @(negedge clk);
    e_valid = 1'b0;
    e_pc    = '0;
    e_instr = '0;
    if (byp_now()) begin
      e_valid = 1'b1;
      e_pc    = in_pc;
      e_instr = in_instr;
    end else if (mq.size() != 0) begin
      e_valid = 1'b1;
      e_pc    = mq[0].pc;
      e_instr = mq[0].instr;
    end
    chk("model_out_valid", 64'(out_valid), 64'(e_valid));
    chk("model_out_pc", 64'(out_pc), 64'(e_pc));
    chk("model_out_instr", 64'(out_instr), 64'(e_instr));
    chk("model_count", 64'(count), 64'(mq.size()));
    chk("model_in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = 1'b0;
    tick();
    in_valid  = 1'b0;
  endtask

  int bias;

  initial begin
    rst      = 1'b1;
    in_pc    = '0;
    in_instr = '0;
    idle();
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Ordered fill, overflow attempt, ordered drain
    for (int i = 0; i < 4; i++) push_one(PC_W'(32'h10 + i), 32'h20080001 + i);
    in_valid = 1'b1;
    in_pc    = PC_W'(32'h14);
    in_instr = 32'h20080005;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fill_5th_ignored", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", 64'(out_pc), 64'h10 + 64'(i));
      chk("drain_instr", 64'(out_instr), 64'h20080001 + 64'(i));
      tick();
    end
    #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    idle();
    tick();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push_one(PC_W'(32'h50 + i), 32'hA0 + i);
    in_valid  = 1'b1;
    in_pc     = PC_W'(32'h54);
    in_instr  = 32'hA4;
    out_ready = 1'b1;
    tick();
    idle();
    #1;
    chk("full_pp_count", 64'(count), 64'd3);
    chk("full_pp_in_ready", 64'(in_ready), 64'd1);
    chk("full_pp_head", 64'(out_pc), 64'h51);
    flush = 1'b1;
    tick();
    idle();

    // Steady stream with wrap-around
    push_one(PC_W'(32'h3F), 32'h3F);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_pc     = PC_W'(32'h40 + i);
      in_instr  = 32'h40 + i;
      out_ready = 1'b1;
      #1;
      chk("wrap_pc", 64'(out_pc), 64'h3F + 64'(i));
      chk("wrap_count", 64'(count), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("wrap_last_pc", 64'(out_pc), 64'h49);
    chk("wrap_last_count", 64'(count), 64'd1);
    tick();
    idle();

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) push_one(PC_W'(32'h60 + i), 32'h60 + i);
    in_valid  = 1'b1;
    in_pc     = PC_W'(32'h80);
    in_instr  = 32'h80;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    idle();
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_0x80", 64'(out_pc == PC_W'(32'h80)), 64'd0);
      tick();
    end

    // Empty-queue forward
    in_valid  = 1'b1;
    in_pc     = PC_W'(32'h20);
    in_instr  = 32'h0000_1234;
    out_ready = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_same_valid", 64'(out_valid), 64'd1);
    chk("byp_same_pc", 64'(out_pc), 64'h20);
`else
    chk("byp_same_valid", 64'(out_valid), 64'd0);
`endif
    tick();
    in_valid = 1'b0;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_next_count", 64'(count), 64'd0);
    chk("byp_next_valid", 64'(out_valid), 64'd0);
`else
    chk("byp_next_valid", 64'(out_valid), 64'd1);
    chk("byp_next_pc", 64'(out_pc), 64'h20);
    chk("byp_next_count", 64'(count), 64'd1);
`endif
    tick();
    idle();
    tick();

    // Asynchronous reset in the middle of a cycle with entries queued
    push_one(PC_W'(32'h70), 32'h70);
    push_one(PC_W'(32'h71), 32'h71);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_out_instr", 64'(out_instr), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Randomized traffic with drifting consumer rate
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(5, 95);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = PC_W'($urandom);
      in_instr  = $urandom;
      out_ready = ($urandom_range(0, 99) < bias);
      flush     = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Instruction queue between the fetch unit and decode in the pipelined core.
- Buffers {word PC, instruction} pairs from fetch using a valid/ready handshake, so a decode stall backpressures fetch without losing instructions.
- A flush on taken branch or jump discards all buffered entries.
- Storage is a circular buffer of DEPTH entries.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PC_W, 30, width of word-aligned PC (byte address bits [31:2])
- INSTR_W, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a valid instruction
- in_ready  output  1  queue accepts the instruction this cycle
- in_pc  input  PC_W  word PC of the incoming instruction
- in_instr  input  INSTR_W  incoming instruction word
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  PC_W  head PC
- out_instr  output  INSTR_W  head instruction
- flush  input  1  discard all entries (taken branch/jump redirect)
- count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out_pc=0, out_instr=0.
  - in_ready=1 once reset is released.
  - Storage contents are don't-care.
- Handshake rules:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Transfer happens on the rising edge when the handshake is high.
  - in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. There is no pass-through when full.
  - out_valid = (count != 0). It depends only on registered state.
- Data path:
  - out_pc and out_instr come from entry[rd_ptr] whenever out_valid=1.
  - When empty, out_pc=0 and out_instr=32'h00000000 (NOP, sll $0,$0,0).
- Latency: an instruction pushed at edge N is visible on out_* after edge N (1 cycle). FIFO order is strict.
- Pointers:
  - log2(DEPTH) bits, increment modulo DEPTH; wrap from DEPTH-1 to 0 is silent.
  - Full/empty is decided by count, not by pointer compare.
- Occupancy updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0. A push attempt is ignored and fetch must hold its PC. A pop in the same cycle still occurs, and in_ready rises the next cycle.
- Empty (count=0): out_valid=0 and out_ready is ignored. Count never underflows.
- Flush:
  - Highest priority. On an edge with flush=1: count=0, rd_ptr=wr_ptr=0.
  - Any push or pop in that cycle is discarded.
  - out_valid=0 from the next cycle.
  - Flush and rst together: reset dominates (same result).
- Reset mid-operation: all entries are lost immediately (async), and outputs go to their reset values in the same cycle.
- No combinational path from in_valid or in_* to out_*, except under the optional feature below.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count=0, flush=0, in_valid=1 and out_ready=1, in_pc/in_instr drive out_pc/out_instr and out_valid=1 combinationally in the same cycle.
  - The entry is consumed without being written, so count stays 0 and the pointers are unchanged.
  - When count=0 and out_ready=0, the entry is written normally.
  - Zero-latency fetch-to-decode when empty.
- Undefined: behaviour exactly as above, with a 1-cycle minimum latency.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle with 2 entries queued.
  - Required: out_valid=0, count=0, out_instr=0 immediately; in_ready=1 after release.
- Ordered fill/drain:
  - Stimulus: with out_ready=0, push PCs 0x10..0x13 with instrs 0x20080001..0x20080004.
  - Required: count=4, in_ready=0, and a 5th push (PC 0x14) is ignored. Then out_ready=1 pops in order 0x10..0x13, count reaches 0 and out_valid=0.
- Simultaneous push/pop at full:
  - Stimulus: count=4, in_valid=1, out_ready=1.
  - Required: pop occurs, push is refused, count=3; next cycle in_ready=1.
- Wrap-around steady stream:
  - Stimulus: push and pop every cycle for 10 cycles, PCs 0x40..0x49, after a 1-entry preload of 0x3F.
  - Required: count stays 1, outputs are 0x3F..0x48 one cycle behind, and the pointers wrap twice without loss.
- Flush priority:
  - Stimulus: count=3; flush=1 together with in_valid=1 (PC 0x80) and out_ready=1.
  - Required: next cycle count=0, out_valid=0, and PC 0x80 never appears on out_pc.
- Bypass (IFQ_BYPASS_EN defined):
  - Stimulus: empty queue, in_valid=1, in_pc=0x20, out_ready=1.
  - Required: same-cycle out_valid=1, out_pc=0x20, and count stays 0.
  - With the macro undefined, the same stimulus gives out_valid=0 that cycle, then out_pc=0x20 on the next.
